// File: rtl/tick_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tick_sequencer
//  Description : Samples a divided clock in the system clock domain. Turns its
//                edges into single-cycle rise/fall strobes, which are used as
//                clock enables. The strobes are gated by a start/stop run
//                controller. The controller counts rising ticks up to a
//                programmed limit, or free-runs when the limit is 0, and it
//                pulses done when the limit is reached.
//  Config      : define TICK_SYNC_EN to place a 2-flop synchroniser in front of
//                the sampling flop. Use this when div_clk comes from a foreign
//                clock domain. Strobe latency then grows from 2 to 4 cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module tick_sequencer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 div_clk,
    input  logic                 start,
    input  logic                 stop,
    input  logic [CNT_WIDTH-1:0] tick_limit,
    output logic                 rise_tick,
    output logic                 fall_tick,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] ticks_elapsed
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic                   w_div_in;
    logic                   r_div_s;
    logic                   r_div_p;
    logic                   w_rise;
    logic                   w_fall;

    logic [CNT_WIDTH-1:0]   r_limit;
    logic [CNT_WIDTH-1:0]   w_limit_next;
    logic [CNT_WIDTH-1:0]   r_ticks;
    logic [CNT_WIDTH-1:0]   w_ticks_next;
    logic [CNT_WIDTH-1:0]   w_cnt_inc;

    logic                   r_rise_tick;
    logic                   r_fall_tick;
    logic                   r_busy;
    logic                   r_done;
    logic                   w_rise_next;
    logic                   w_fall_next;
    logic                   w_busy_next;
    logic                   w_done_next;

`ifdef TICK_SYNC_EN
    logic                   r_sync1;
    logic                   r_sync2;

    // Two-flop synchroniser for a div_clk generated in another clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= div_clk;
            r_sync2 <= r_sync1;
        end
    end

    assign w_div_in = r_sync2;
`else
    assign w_div_in = div_clk;
`endif

    // Edge history: current sample and previous sample of the divided clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_s <= 1'b0;
            r_div_p <= 1'b0;
        end else begin
            r_div_s <= w_div_in;
            r_div_p <= r_div_s;
        end
    end

    assign w_rise    = r_div_s & ~r_div_p;
    assign w_fall    = ~r_div_s & r_div_p;
    assign w_cnt_inc = r_ticks + CNT_WIDTH'(1);

    // FSM state register together with the latched limit and the tick counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_limit <= '0;
            r_ticks <= '0;
        end else begin
            r_state <= w_state_next;
            r_limit <= w_limit_next;
            r_ticks <= w_ticks_next;
        end
    end

    // Next-state logic. In RUN, stop wins over any edge that arrives in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_limit_next = r_limit;
        w_ticks_next = r_ticks;
        w_rise_next  = 1'b0;
        w_fall_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_state_next = S_RUN;
                    w_limit_next = tick_limit;
                    w_ticks_next = '0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_state_next = S_IDLE;
                end else if (w_rise) begin
                    w_rise_next  = 1'b1;
                    w_ticks_next = w_cnt_inc;
                    if ((r_limit != '0) && (w_cnt_inc == r_limit)) begin
                        w_state_next = S_DONE;
                    end
                end else if (w_fall) begin
                    w_fall_next = 1'b1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // busy tracks entry into and exit from RUN with no lag.
    // done is taken from the DONE state, so it lands one cycle after the final rise_tick.
    assign w_busy_next = (w_state_next == S_RUN);
    assign w_done_next = (r_state == S_DONE);

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rise_tick <= 1'b0;
            r_fall_tick <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_rise_tick <= w_rise_next;
            r_fall_tick <= w_fall_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
        end
    end

    assign rise_tick     = r_rise_tick;
    assign fall_tick     = r_fall_tick;
    assign busy          = r_busy;
    assign done          = r_done;
    assign ticks_elapsed = r_ticks;

endmodule
`default_nettype wire

// File: tb/tb_tick_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tick_sequencer
//  Description : Scoreboard bench for tick_sequencer. The stimulus tasks push
//                the expected strobes into a queue, each with its cycle and its
//                count. A monitor pops that queue and compares it against the
//                DUT outputs. Build with TICK_SYNC_EN to check the
//                synchronised configuration.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tick_sequencer;

    localparam int CW = 4;
`ifdef TICK_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          div_clk;
    logic          start;
    logic          stop;
    logic [CW-1:0] tick_limit;
    logic          rise_tick;
    logic          fall_tick;
    logic          busy;
    logic          done;
    logic [CW-1:0] ticks_elapsed;

    tick_sequencer #(.CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .div_clk       (div_clk),
        .start         (start),
        .stop          (stop),
        .tick_limit    (tick_limit),
        .rise_tick     (rise_tick),
        .fall_tick     (fall_tick),
        .busy          (busy),
        .done          (done),
        .ticks_elapsed (ticks_elapsed)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = rise_tick, 1 = fall_tick, 2 = done
    typedef struct {
        int kind;
        int cnt;
        int at;
    } ev_t;

    ev_t q[$];
    int  n_pass  = 0;
    int  n_total = 0;
    bit  exp_run = 1'b0;
    int  exp_cnt = 0;
    int  exp_lim = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive div_clk. While a run is expected, push the strobe it should cause.
    task automatic drive_div(input logic v);
        if ((v !== div_clk) && exp_run) begin
            if (v) begin
                exp_cnt = (exp_cnt + 1) % 16;
                q.push_back('{kind: 0, cnt: exp_cnt, at: cyc + LAT});
                if ((exp_lim != 0) && (exp_cnt == exp_lim)) begin
                    q.push_back('{kind: 2, cnt: exp_cnt, at: cyc + LAT + 1});
                    exp_run = 1'b0;
                end
            end else begin
                q.push_back('{kind: 1, cnt: exp_cnt, at: cyc + LAT});
            end
        end
        div_clk = v;
    endtask

    // Divide-by-4 waveform: 2 cycles high, then 2 cycles low
    task automatic pulse(input int n);
        repeat (n) begin
            drive_div(1'b1);
            tick(2);
            drive_div(1'b0);
            tick(2);
        end
    endtask

    task automatic do_start(input int lim);
        tick_limit = CW'(lim);
        start      = 1'b1;
        tick(1);
        start      = 1'b0;
        if (!exp_run) begin
            exp_run = 1'b1;
            exp_cnt = 0;
            exp_lim = lim;
        end
    endtask

    // Monitor: pop and compare on each strobe, and flag any strobe that is overdue
    task automatic monitor_loop();
        ev_t        e;
        logic [2:0] mask;
        logic [2:0] emask;
        forever begin
            @(negedge clk);
            mask = {done, fall_tick, rise_tick};
            if (mask != 3'b000) begin
                if (q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_strobe: got mask %b ticks %0d at cycle %0d, expected none",
                             mask, ticks_elapsed, cyc);
                end else begin
                    e     = q.pop_front();
                    emask = 3'b001 << e.kind;
                    n_total++;
                    if ((mask == emask) && (cyc == e.at) && (int'(ticks_elapsed) == e.cnt)) n_pass++;
                    else $display("FAIL strobe: got mask %b ticks %0d cycle %0d, expected mask %b ticks %0d cycle %0d",
                                  mask, ticks_elapsed, cyc, emask, e.cnt, e.at);
                end
            end else if ((q.size() > 0) && (q[0].at <= cyc)) begin
                e     = q.pop_front();
                emask = 3'b001 << e.kind;
                n_total++;
                $display("FAIL missing_strobe: got none at cycle %0d, expected mask %b ticks %0d",
                         cyc, emask, e.cnt);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        div_clk    = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        tick_limit = '0;
        fork
            monitor_loop();
        join_none
        tick(3);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_ticks", ticks_elapsed, 0);
        check("reset_rise", rise_tick, 0);
        check("reset_fall", fall_tick, 0);
        rst = 1'b0;
        tick(3);

        // Counted run: limit 3 gives 3 rises 4 cycles apart, then done. The 4th pulse is ignored.
        do_start(3);
        check("start_busy", busy, 1);
        check("start_ticks", ticks_elapsed, 0);
        pulse(4);
        tick(4);
        check("counted_ticks_held", ticks_elapsed, 3);
        check("counted_busy_low", busy, 0);

        // Reset in the middle of a run
        do_start(5);
        pulse(2);
        tick(4);
        check("prereset_ticks", ticks_elapsed, 2);
        rst     = 1'b1;
        exp_run = 1'b0;
        tick(1);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_ticks", ticks_elapsed, 0);
        rst = 1'b0;
        tick(2);
        pulse(2);
        tick(4);
        check("postrst_ticks", ticks_elapsed, 0);

        // Free run wraps modulo 16. A start issued during RUN is ignored.
        do_start(0);
        pulse(8);
        do_start(1);
        pulse(9);
        tick(4);
        check("wrap_ticks", ticks_elapsed, 1);
        check("wrap_busy", busy, 1);
        stop = 1'b1;
        tick(1);
        stop    = 1'b0;
        exp_run = 1'b0;
        check("stop_busy", busy, 0);
        pulse(1);
        tick(4);
        check("stop_ticks_held", ticks_elapsed, 1);

        // start and stop asserted together in IDLE
        tick_limit = 4'd1;
        start      = 1'b1;
        stop       = 1'b1;
        tick(1);
        start = 1'b0;
        stop  = 1'b0;
        check("startstop_busy", busy, 0);
        pulse(1);
        tick(4);
        check("startstop_ticks", ticks_elapsed, 1);

        // stop arrives in the same cycle as the final rise (limit 2)
        do_start(2);
        pulse(1);
        exp_run = 1'b0;
        div_clk = 1'b1;
        tick(LAT - 1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check("contend_busy", busy, 0);
        tick(2);
        div_clk = 1'b0;
        tick(4);
        check("contend_ticks", ticks_elapsed, 1);

        // Start while div_clk is high: the fall comes first, then the counted rise and done
        drive_div(1'b1);
        tick(6);
        do_start(1);
        check("midphase_ticks0", ticks_elapsed, 0);
        tick(1);
        drive_div(1'b0);
        tick(2);
        drive_div(1'b1);
        tick(2);
        drive_div(1'b0);
        tick(6);
        check("midphase_ticks1", ticks_elapsed, 1);
        check("midphase_busy", busy, 0);

        tick(10);
        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
